mode1_handshake_ctrl: RTL and testbench
=======================================

MODE1_HANDSHAKE_CTRL -- requirements
Module: mode1_handshake_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on RD, WR, STB and ACK; legal values are 2 and 3.
REQ-002 CLK  in  1  system clock; all state changes on its rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 RD  in  1  active-low CPU read strobe, asynchronous to CLK.
REQ-005 WR  in  1  active-low CPU write strobe, asynchronous to CLK.
REQ-006 PORT_SEL  in  1  the CPU cycle targets this port; qualifies RD and WR edges.
REQ-007 DIR  in  1  1 = strobed input mode, 0 = strobed output mode.
REQ-008 INTE_WR  in  1  one-CLK pulse that loads INTE from INTE_VAL.
REQ-009 INTE_VAL  in  1  interrupt-enable value to load.
REQ-010 D_IN  in  8  CPU write data.
REQ-011 D_OUT  out  8  CPU read data: the input latch.
REQ-012 PA_IN  in  8  peripheral input data.
REQ-013 PA_OUT  out  8  peripheral output latch.
REQ-014 PA_OE  out  1  peripheral pin drive enable; equals ~DIR.
REQ-015 STB  in  1  active-low peripheral strobe (input mode).
REQ-016 ACK  in  1  active-low peripheral acknowledge (output mode).
REQ-017 IBF  out  1  input buffer full.
REQ-018 OBF_n  out  1  active-low output buffer full.
REQ-019 INTR  out  1  interrupt request to the CPU.

Function
REQ-020 RD, WR, STB and ACK each pass through SYNC_STAGES flops; edges are detected on the synchronized value against a one-flop delayed copy, so the response registers on the (SYNC_STAGES+1)th rising CLK edge after the pin change.
REQ-021 FSM states: IDLE, IN_FULL, IN_RD, OUT_FULL, OUT_ACK.
REQ-022 Input mode, IDLE, STB fall: latch PA_IN (pin value at the detect edge) into D_OUT; IBF=1; go to IN_FULL.
REQ-023 IN_FULL, STB rise: INTR=INTE.
REQ-024 IN_FULL, RD fall with PORT_SEL=1: INTR=0; go to IN_RD.
REQ-025 IN_RD, RD rise: IBF=0; go to IDLE.
REQ-026 STB fall while IBF=1: ignored; the latch holds its old value.
REQ-027 Output mode, IDLE or OUT_FULL, WR fall with PORT_SEL=1: INTR=0.
REQ-028 Output mode, IDLE or OUT_FULL, WR rise with PORT_SEL=1: PA_OUT=D_IN; OBF_n=0; go to OUT_FULL.
REQ-029 OUT_FULL, ACK fall: OBF_n=1; go to OUT_ACK.
REQ-030 OUT_ACK, ACK rise: INTR=INTE; go to IDLE.
REQ-031 A WR rise in OUT_ACK is deferred until the FSM returns to IDLE; at most one deferred write is held.
REQ-032 An RD or WR edge with PORT_SEL=0, or of the wrong kind for the current mode, has no effect.
REQ-033 A DIR change, detected on the registered DIR: next state IDLE, IBF=0, OBF_n=1, INTR=0; the latches hold their values.
REQ-034 The DIR change takes priority over every same-cycle handshake edge.
REQ-035 INTE_WR with INTE_VAL=0 forces INTR=0 on the same edge; INTE_VAL=1 does not set a pending INTR retroactively.
REQ-036 Same-cycle STB rise and RD fall in IN_FULL: the RD fall wins, so INTR=0.

Reset
REQ-037 RESET asserted: state=IDLE, IBF=0, OBF_n=1, INTR=0, INTE=0, D_OUT=0, PA_OUT=0, synchronizers at 1 (inactive).
REQ-038 Reset takes effect immediately and asynchronously; mid-handshake state is discarded.
REQ-039 Release is synchronous to CLK, with the first handshake evaluation on the following edge.

Configuration
REQ-040 Macro OVERRUN_DET_EN, when defined, adds output OVR (out, 1).
REQ-041 OVR is sticky and sets on an ignored STB fall (REQ-026) or on a WR rise while OBF_n=0.
REQ-042 OVR is cleared by RESET, a DIR change, or an RD fall with PORT_SEL=1; its reset value is 0.
REQ-043 Macro not defined: no OVR port and no overrun logic; behaviour otherwise identical.

Verification
REQ-044 Input: DIR=1, INTE=1, PA_IN=8'hA5, STB low then high -> IBF=1 and D_OUT=8'hA5 3 CLK after the fall; INTR=1 3 CLK after the rise.
REQ-045 Input read: RD pulse with PORT_SEL=1 -> INTR=0 after the RD fall, IBF=0 after the RD rise; a second STB with PA_IN=8'h3C then latches 8'h3C.
REQ-046 Output: DIR=0, INTE=1, D_IN=8'h5A, WR pulse -> PA_OUT=8'h5A, OBF_n=0; ACK pulse -> OBF_n=1 after the fall, INTR=1 after the rise.
REQ-047 Overrun: with IBF=1, STB pulse with PA_IN=8'hFF -> D_OUT unchanged; OVR=1 when OVERRUN_DET_EN is defined.
REQ-048 Mid-operation: in OUT_FULL, toggle DIR -> IDLE, OBF_n=1, INTR=0; async RESET mid-STB -> all outputs at reset values with no CLK edge needed.

Source files
------------

// File: rtl/mode1_handshake_ctrl_if.sv
// Signal bundle for the mode-1 strobed port: CPU bus, peripheral pins and handshake lines.
// The ovr flag exists only when OVERRUN_DET_EN is defined.
interface mode1_handshake_ctrl_if;
  logic       rd;
  logic       wr;
  logic       port_sel;
  logic       dir;
  logic       inte_wr;
  logic       inte_val;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic [7:0] pa_in;
  logic [7:0] pa_out;
  logic       pa_oe;
  logic       stb;
  logic       ack;
  logic       ibf;
  logic       obf_n;
  logic       intr;
`ifdef OVERRUN_DET_EN
  logic       ovr;

  modport master (
    output rd, wr, port_sel, dir, inte_wr, inte_val, d_in, pa_in, stb, ack,
    input  d_out, pa_out, pa_oe, ibf, obf_n, intr, ovr
  );

  modport slave (
    input  rd, wr, port_sel, dir, inte_wr, inte_val, d_in, pa_in, stb, ack,
    output d_out, pa_out, pa_oe, ibf, obf_n, intr, ovr
  );
`else
  modport master (
    output rd, wr, port_sel, dir, inte_wr, inte_val, d_in, pa_in, stb, ack,
    input  d_out, pa_out, pa_oe, ibf, obf_n, intr
  );

  modport slave (
    input  rd, wr, port_sel, dir, inte_wr, inte_val, d_in, pa_in, stb, ack,
    output d_out, pa_out, pa_oe, ibf, obf_n, intr
  );
`endif
endinterface

// File: rtl/mode1_handshake_ctrl.sv
// 8255-style mode-1 strobed I/O port controller with synchronized RD/WR/STB/ACK handshakes.
// Defining OVERRUN_DET_EN adds a sticky overrun flag (ovr).
module mode1_handshake_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                   clk,
  input logic                   rst,
  mode1_handshake_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StInFull, StInRd, StOutFull, StOutAck} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] rd_sync_q, wr_sync_q, stb_sync_q, ack_sync_q;
  logic rd_dly_q, wr_dly_q, stb_dly_q, ack_dly_q;
  logic rd_s, wr_s, stb_s, ack_s;
  logic rd_fall_sel, rd_rise_sel, wr_fall_sel, wr_rise_sel;
  logic stb_fall, stb_rise, ack_fall, ack_rise;

  logic       dir_q, dir_prev_q, dir_change;
  logic       inte_q;
  logic       ibf_q, ibf_d;
  logic       obf_n_q, obf_n_d;
  logic       intr_q, intr_d;
  logic [7:0] d_out_q, d_out_d;
  logic [7:0] pa_out_q, pa_out_d;
  logic       pend_q, pend_d;
  logic [7:0] pend_data_q, pend_data_d;

  // Synchronizers idle high so reset never looks like a strobe edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sync_q  <= '1;
      wr_sync_q  <= '1;
      stb_sync_q <= '1;
      ack_sync_q <= '1;
      rd_dly_q   <= 1'b1;
      wr_dly_q   <= 1'b1;
      stb_dly_q  <= 1'b1;
      ack_dly_q  <= 1'b1;
    end else begin
      rd_sync_q  <= {rd_sync_q[SYNC_STAGES-2:0], bus.rd};
      wr_sync_q  <= {wr_sync_q[SYNC_STAGES-2:0], bus.wr};
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], bus.stb};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack};
      rd_dly_q   <= rd_s;
      wr_dly_q   <= wr_s;
      stb_dly_q  <= stb_s;
      ack_dly_q  <= ack_s;
    end
  end

  assign rd_s  = rd_sync_q[SYNC_STAGES-1];
  assign wr_s  = wr_sync_q[SYNC_STAGES-1];
  assign stb_s = stb_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  assign rd_fall_sel = rd_dly_q & ~rd_s & bus.port_sel;
  assign rd_rise_sel = ~rd_dly_q & rd_s & bus.port_sel;
  assign wr_fall_sel = wr_dly_q & ~wr_s & bus.port_sel;
  assign wr_rise_sel = ~wr_dly_q & wr_s & bus.port_sel;
  assign stb_fall    = stb_dly_q & ~stb_s;
  assign stb_rise    = ~stb_dly_q & stb_s;
  assign ack_fall    = ack_dly_q & ~ack_s;
  assign ack_rise    = ~ack_dly_q & ack_s;

  assign dir_change  = dir_q ^ dir_prev_q;

  always_comb begin
    state_d     = state_q;
    ibf_d       = ibf_q;
    obf_n_d     = obf_n_q;
    intr_d      = intr_q;
    d_out_d     = d_out_q;
    pa_out_d    = pa_out_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;

    if (dir_change) begin
      state_d = StIdle;
      ibf_d   = 1'b0;
      obf_n_d = 1'b1;
      intr_d  = 1'b0;
      pend_d  = 1'b0;
    end else if (dir_q) begin
      case (state_q)
        StIdle: begin
          if (stb_fall) begin
            d_out_d = bus.pa_in;
            ibf_d   = 1'b1;
            state_d = StInFull;
          end
        end
        StInFull: begin
          // A same-cycle RD fall beats the STB rise, leaving INTR low.
          if (rd_fall_sel) begin
            intr_d  = 1'b0;
            state_d = StInRd;
          end else if (stb_rise) begin
            intr_d = inte_q;
          end
        end
        StInRd: begin
          if (rd_rise_sel) begin
            ibf_d   = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end else begin
      case (state_q)
        StIdle, StOutFull: begin
          if (wr_fall_sel) intr_d = 1'b0;
          if (state_q == StOutFull && ack_fall) begin
            obf_n_d = 1'b1;
            state_d = StOutAck;
            if (wr_rise_sel) begin
              pend_d      = 1'b1;
              pend_data_d = bus.d_in;
            end
          end else if (wr_rise_sel) begin
            pa_out_d = bus.d_in;
            obf_n_d  = 1'b0;
            state_d  = StOutFull;
            pend_d   = 1'b0;
          end else if (pend_q) begin
            pa_out_d = pend_data_q;
            obf_n_d  = 1'b0;
            state_d  = StOutFull;
            pend_d   = 1'b0;
          end
        end
        StOutAck: begin
          // Writes during the acknowledge are parked and replayed from IDLE.
          if (wr_rise_sel) begin
            pend_d      = 1'b1;
            pend_data_d = bus.d_in;
          end
          if (ack_rise) begin
            intr_d  = inte_q;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (bus.inte_wr && !bus.inte_val) intr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ibf_q       <= 1'b0;
      obf_n_q     <= 1'b1;
      intr_q      <= 1'b0;
      inte_q      <= 1'b0;
      d_out_q     <= '0;
      pa_out_q    <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      dir_q       <= 1'b0;
      dir_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ibf_q       <= ibf_d;
      obf_n_q     <= obf_n_d;
      intr_q      <= intr_d;
      d_out_q     <= d_out_d;
      pa_out_q    <= pa_out_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      dir_q       <= bus.dir;
      dir_prev_q  <= dir_q;
      if (bus.inte_wr) inte_q <= bus.inte_val;
    end
  end

  assign bus.d_out  = d_out_q;
  assign bus.pa_out = pa_out_q;
  assign bus.pa_oe  = ~bus.dir;
  assign bus.ibf    = ibf_q;
  assign bus.obf_n  = obf_n_q;
  assign bus.intr   = intr_q;

`ifdef OVERRUN_DET_EN
  logic ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (rd_fall_sel) ovr_d = 1'b0;
    if (dir_q ? (stb_fall & ibf_q) : (wr_rise_sel & ~obf_n_q)) ovr_d = 1'b1;
    if (dir_change) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= ovr_d;
  end

  assign bus.ovr = ovr_q;
`endif

endmodule

// File: tb/tb_mode1_handshake_ctrl.sv
// Scoreboard bench for mode1_handshake_ctrl: latched data is queued when driven and
// checked when IBF rises / OBF_n falls; scenario tasks check handshake timing inline.
module tb_mode1_handshake_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mode1_handshake_ctrl_if bus ();

  mode1_handshake_ctrl #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  logic       ibf_prev   = 1'b0;
  logic       obf_n_prev = 1'b1;

  // Scoreboard side: pop an expectation whenever the DUT reports a new buffer event.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ibf && !ibf_prev) begin
        checks++;
        if (in_q.size() == 0) begin
          fails++;
          $display("FAIL sb_in_unexpected: ibf rose with d_out=%h, nothing expected", bus.d_out);
        end else begin
          logic [7:0] e;
          e = in_q.pop_front();
          if (bus.d_out !== e) begin
            fails++;
            $display("FAIL sb_in_data: got %h want %h", bus.d_out, e);
          end else passes++;
        end
      end
      if (!bus.obf_n && obf_n_prev) begin
        checks++;
        if (out_q.size() == 0) begin
          fails++;
          $display("FAIL sb_out_unexpected: obf_n fell with pa_out=%h", bus.pa_out);
        end else begin
          logic [7:0] e;
          e = out_q.pop_front();
          if (bus.pa_out !== e) begin
            fails++;
            $display("FAIL sb_out_data: got %h want %h", bus.pa_out, e);
          end else passes++;
        end
      end
    end
    ibf_prev   <= bus.ibf;
    obf_n_prev <= bus.obf_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv_edge();
    @(negedge clk);
  endtask

  task automatic inte_load(input logic v);
    drv_edge();
    bus.inte_wr = 1'b1;
    bus.inte_val = v;
    drv_edge();
    bus.inte_wr = 1'b0;
  endtask

  task automatic do_read();
    drv_edge(); bus.port_sel = 1'b1; bus.rd = 1'b0; cyc(3);
    drv_edge(); bus.rd = 1'b1; cyc(3);
  endtask

  task automatic test_reset();
    bus.rd = 1'b1; bus.wr = 1'b1; bus.stb = 1'b1; bus.ack = 1'b1;
    bus.port_sel = 1'b0; bus.dir = 1'b0; bus.inte_wr = 1'b0; bus.inte_val = 1'b0;
    bus.d_in = 8'h00; bus.pa_in = 8'h00;
    rst = 1'b1;
    cyc(3);
    checks++; if (bus.ibf !== 1'b0) begin fails++; $display("FAIL rst_ibf: got %b want 0", bus.ibf); end else passes++;
    checks++; if (bus.obf_n !== 1'b1) begin fails++; $display("FAIL rst_obf_n: got %b want 1", bus.obf_n); end else passes++;
    checks++; if (bus.intr !== 1'b0) begin fails++; $display("FAIL rst_intr: got %b want 0", bus.intr); end else passes++;
    checks++; if (bus.d_out !== 8'h00) begin fails++; $display("FAIL rst_d_out: got %h want 00", bus.d_out); end else passes++;
    checks++; if (bus.pa_out !== 8'h00) begin fails++; $display("FAIL rst_pa_out: got %h want 00", bus.pa_out); end else passes++;
    checks++; if (bus.pa_oe !== 1'b1) begin fails++; $display("FAIL rst_pa_oe: got %b want 1", bus.pa_oe); end else passes++;
`ifdef OVERRUN_DET_EN
    checks++; if (bus.ovr !== 1'b0) begin fails++; $display("FAIL rst_ovr: got %b want 0", bus.ovr); end else passes++;
`endif
    drv_edge(); rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_input();
    drv_edge(); bus.dir = 1'b1;
    cyc(4);
    checks++; if (bus.pa_oe !== 1'b0) begin fails++; $display("FAIL in_pa_oe: got %b want 0", bus.pa_oe); end else passes++;
    inte_load(1'b1);
    drv_edge(); bus.pa_in = 8'hA5; in_q.push_back(8'hA5); bus.stb = 1'b0;
    cyc(2);
    checks++; if (bus.ibf !== 1'b0) begin fails++; $display("FAIL in_ibf_early: got %b want 0", bus.ibf); end else passes++;
    cyc(1);
    checks++; if (bus.ibf !== 1'b1) begin fails++; $display("FAIL in_ibf: got %b want 1", bus.ibf); end else passes++;
    checks++; if (bus.d_out !== 8'hA5) begin fails++; $display("FAIL in_d_out: got %h want a5", bus.d_out); end else passes++;
    drv_edge(); bus.pa_in = 8'h00; bus.stb = 1'b1;
    cyc(2);
    checks++; if (bus.intr !== 1'b0) begin fails++; $display("FAIL in_intr_early: got %b want 0", bus.intr); end else passes++;
    cyc(1);
    checks++; if (bus.intr !== 1'b1) begin fails++; $display("FAIL in_intr: got %b want 1", bus.intr); end else passes++;
  endtask

  task automatic test_input_overrun();
    drv_edge(); bus.pa_in = 8'hFF; bus.stb = 1'b0;
    cyc(3);
    checks++; if (bus.d_out !== 8'hA5) begin fails++; $display("FAIL ovr_d_out_hold: got %h want a5", bus.d_out); end else passes++;
    checks++; if (bus.ibf !== 1'b1) begin fails++; $display("FAIL ovr_ibf: got %b want 1", bus.ibf); end else passes++;
`ifdef OVERRUN_DET_EN
    checks++; if (bus.ovr !== 1'b1) begin fails++; $display("FAIL ovr_in_set: got %b want 1", bus.ovr); end else passes++;
`endif
    drv_edge(); bus.stb = 1'b1;
    cyc(3);
  endtask

  task automatic test_read();
    drv_edge(); bus.port_sel = 1'b1; bus.rd = 1'b0;
    cyc(3);
    checks++; if (bus.intr !== 1'b0) begin fails++; $display("FAIL rd_intr_clr: got %b want 0", bus.intr); end else passes++;
    checks++; if (bus.ibf !== 1'b1) begin fails++; $display("FAIL rd_ibf_hold: got %b want 1", bus.ibf); end else passes++;
`ifdef OVERRUN_DET_EN
    checks++; if (bus.ovr !== 1'b0) begin fails++; $display("FAIL rd_ovr_clr: got %b want 0", bus.ovr); end else passes++;
`endif
    drv_edge(); bus.rd = 1'b1;
    cyc(3);
    checks++; if (bus.ibf !== 1'b0) begin fails++; $display("FAIL rd_ibf_clr: got %b want 0", bus.ibf); end else passes++;
    drv_edge(); bus.pa_in = 8'h3C; in_q.push_back(8'h3C); bus.stb = 1'b0;
    cyc(3);
    checks++; if (bus.d_out !== 8'h3C) begin fails++; $display("FAIL rd_second_latch: got %h want 3c", bus.d_out); end else passes++;
    drv_edge(); bus.stb = 1'b1;
    cyc(3);
  endtask

  task automatic test_port_sel_gate();
    drv_edge(); bus.port_sel = 1'b0; bus.rd = 1'b0; cyc(3);
    drv_edge(); bus.rd = 1'b1; cyc(3);
    checks++; if (bus.intr !== 1'b1) begin fails++; $display("FAIL gate_intr: got %b want 1", bus.intr); end else passes++;
    checks++; if (bus.ibf !== 1'b1) begin fails++; $display("FAIL gate_ibf: got %b want 1", bus.ibf); end else passes++;
    do_read();
    checks++; if (bus.ibf !== 1'b0) begin fails++; $display("FAIL gate_read_ibf: got %b want 0", bus.ibf); end else passes++;
  endtask

  task automatic test_output();
    drv_edge(); bus.dir = 1'b0;
    cyc(4);
    checks++; if (bus.pa_oe !== 1'b1) begin fails++; $display("FAIL out_pa_oe: got %b want 1", bus.pa_oe); end else passes++;
    drv_edge(); bus.port_sel = 1'b1; bus.d_in = 8'h5A; out_q.push_back(8'h5A); bus.wr = 1'b0;
    cyc(3);
    drv_edge(); bus.wr = 1'b1;
    cyc(2);
    checks++; if (bus.obf_n !== 1'b1) begin fails++; $display("FAIL out_obf_early: got %b want 1", bus.obf_n); end else passes++;
    cyc(1);
    checks++; if (bus.obf_n !== 1'b0) begin fails++; $display("FAIL out_obf_n: got %b want 0", bus.obf_n); end else passes++;
    checks++; if (bus.pa_out !== 8'h5A) begin fails++; $display("FAIL out_pa_out: got %h want 5a", bus.pa_out); end else passes++;
    drv_edge(); bus.ack = 1'b0;
    cyc(3);
    checks++; if (bus.obf_n !== 1'b1) begin fails++; $display("FAIL out_ack_obf: got %b want 1", bus.obf_n); end else passes++;
    drv_edge(); bus.ack = 1'b1;
    cyc(3);
    checks++; if (bus.intr !== 1'b1) begin fails++; $display("FAIL out_ack_intr: got %b want 1", bus.intr); end else passes++;
  endtask

  task automatic test_output_overrun();
    drv_edge(); bus.d_in = 8'h11; out_q.push_back(8'h11); bus.wr = 1'b0;
    cyc(3);
    checks++; if (bus.intr !== 1'b0) begin fails++; $display("FAIL wr_fall_intr: got %b want 0", bus.intr); end else passes++;
    drv_edge(); bus.wr = 1'b1; cyc(3);
    drv_edge(); bus.d_in = 8'h33; bus.wr = 1'b0; cyc(3);
    drv_edge(); bus.wr = 1'b1; cyc(3);
    checks++; if (bus.pa_out !== 8'h33) begin fails++; $display("FAIL ovw_pa_out: got %h want 33", bus.pa_out); end else passes++;
    checks++; if (bus.obf_n !== 1'b0) begin fails++; $display("FAIL ovw_obf_n: got %b want 0", bus.obf_n); end else passes++;
`ifdef OVERRUN_DET_EN
    checks++; if (bus.ovr !== 1'b1) begin fails++; $display("FAIL ovr_out_set: got %b want 1", bus.ovr); end else passes++;
`endif
    drv_edge(); bus.ack = 1'b0; cyc(3);
    drv_edge(); bus.ack = 1'b1; cyc(3);
  endtask

  task automatic test_back_to_back();
    drv_edge(); bus.d_in = 8'h66; out_q.push_back(8'h66); bus.wr = 1'b0; cyc(3);
    drv_edge(); bus.wr = 1'b1; cyc(3);
    drv_edge(); bus.ack = 1'b0; cyc(3);
    drv_edge(); bus.d_in = 8'h22; out_q.push_back(8'h22); bus.wr = 1'b0; cyc(3);
    drv_edge(); bus.wr = 1'b1; cyc(3);
    drv_edge(); bus.d_in = 8'h77;
    checks++; if (bus.obf_n !== 1'b1) begin fails++; $display("FAIL defer_obf_n: got %b want 1", bus.obf_n); end else passes++;
    checks++; if (bus.pa_out !== 8'h66) begin fails++; $display("FAIL defer_pa_hold: got %h want 66", bus.pa_out); end else passes++;
    bus.ack = 1'b1;
    cyc(3);
    checks++; if (bus.intr !== 1'b1) begin fails++; $display("FAIL defer_intr: got %b want 1", bus.intr); end else passes++;
    cyc(1);
    checks++; if (bus.obf_n !== 1'b0) begin fails++; $display("FAIL defer_replay_obf: got %b want 0", bus.obf_n); end else passes++;
    checks++; if (bus.pa_out !== 8'h22) begin fails++; $display("FAIL defer_replay_pa: got %h want 22", bus.pa_out); end else passes++;
  endtask

  task automatic test_dir_change();
    drv_edge(); bus.dir = 1'b1;
    cyc(3);
    checks++; if (bus.obf_n !== 1'b1) begin fails++; $display("FAIL dir_obf_n: got %b want 1", bus.obf_n); end else passes++;
    checks++; if (bus.intr !== 1'b0) begin fails++; $display("FAIL dir_intr: got %b want 0", bus.intr); end else passes++;
    checks++; if (bus.pa_out !== 8'h22) begin fails++; $display("FAIL dir_pa_hold: got %h want 22", bus.pa_out); end else passes++;
`ifdef OVERRUN_DET_EN
    checks++; if (bus.ovr !== 1'b0) begin fails++; $display("FAIL dir_ovr_clr: got %b want 0", bus.ovr); end else passes++;
`endif
    cyc(2);
  endtask

  task automatic test_inte_clear();
    drv_edge(); bus.pa_in = 8'h99; in_q.push_back(8'h99); bus.stb = 1'b0; cyc(3);
    drv_edge(); bus.stb = 1'b1; cyc(3);
    checks++; if (bus.intr !== 1'b1) begin fails++; $display("FAIL inte_pre: got %b want 1", bus.intr); end else passes++;
    drv_edge(); bus.inte_wr = 1'b1; bus.inte_val = 1'b0;
    cyc(1);
    checks++; if (bus.intr !== 1'b0) begin fails++; $display("FAIL inte_clr: got %b want 0", bus.intr); end else passes++;
    drv_edge(); bus.inte_wr = 1'b0;
    inte_load(1'b1);
    cyc(2);
    checks++; if (bus.intr !== 1'b0) begin fails++; $display("FAIL inte_no_retro: got %b want 0", bus.intr); end else passes++;
    do_read();
  endtask

  task automatic test_async_reset();
    drv_edge(); bus.pa_in = 8'hC3; in_q.push_back(8'hC3); bus.stb = 1'b0; cyc(3);
    drv_edge(); bus.stb = 1'b1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.ibf !== 1'b0) begin fails++; $display("FAIL arst_ibf: got %b want 0", bus.ibf); end else passes++;
    checks++; if (bus.d_out !== 8'h00) begin fails++; $display("FAIL arst_d_out: got %h want 00", bus.d_out); end else passes++;
    checks++; if (bus.pa_out !== 8'h00) begin fails++; $display("FAIL arst_pa_out: got %h want 00", bus.pa_out); end else passes++;
    checks++; if (bus.obf_n !== 1'b1) begin fails++; $display("FAIL arst_obf_n: got %b want 1", bus.obf_n); end else passes++;
    checks++; if (bus.intr !== 1'b0) begin fails++; $display("FAIL arst_intr: got %b want 0", bus.intr); end else passes++;
    drv_edge(); rst = 1'b0;
    cyc(5);
    checks++; if (bus.intr !== 1'b0) begin fails++; $display("FAIL arst_post_intr: got %b want 0", bus.intr); end else passes++;
    checks++; if (in_q.size() != 0 || out_q.size() != 0) begin
      fails++; $display("FAIL sb_drain: got in=%0d out=%0d pending, want 0", in_q.size(), out_q.size());
    end else passes++;
  endtask

  initial begin
    test_reset();
    test_input();
    test_input_overrun();
    test_read();
    test_port_sel_gate();
    test_output();
    test_output_overrun();
    test_back_to_back();
    test_dir_change();
    test_inte_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
